// File: rtl/ram_sequencer.sv
// ram_sequencer: turns one byte/half/word load or store request into a
// sequence of single-byte accesses on a byte-wide synchronous block RAM.
//
// Each byte goes through SETUP (address/data/enables presented) and CAPTURE
// (enables held while the RAM performs its registered read). Every output
// is registered from the state of the previous cycle. This places the RAM
// strobe one cycle after SETUP, so the read byte is captured one cycle later
// still. Completion (done) follows 2n+1 edges after the edge that accepted
// start, where n is the byte count.
//
// Optional feature: define RAM_SEQ_MISALIGN_TRAP_EN to reject misaligned
// half/word accesses. Such an access skips the RAM entirely and completes
// with error=1. Without the macro, misaligned accesses are performed bytewise
// and error stays 0.

module ram_sequencer #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [1:0]            size,
  input  logic                  is_signed,
  input  logic                  write,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [7:0]            ram_data_in,
  input  logic [7:0]            ram_data_out,
  output logic                  ram_chip_enable,
  output logic                  ram_write_enable
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  // Sequencing state
  logic [1:0]            state_reg, state_next;
  logic [1:0]            k_reg, k_next;
  logic [1:0]            last_k_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  signed_reg;
  logic                  write_reg;
  logic                  trap_reg;
  logic [31:0]           wdata_reg;

  // Request decode
  logic                  accept;
  logic                  misaligned;
  logic [1:0]            req_last_k;

  // Registered outputs
  logic [31:0]           rdata_reg, rdata_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  error_reg, error_next;
  logic [ADDR_WIDTH-1:0] ram_address_reg, ram_address_next;
  logic [7:0]            ram_data_in_reg, ram_data_in_next;
  logic                  ram_ce_reg, ram_ce_next;
  logic                  ram_we_reg, ram_we_next;

  // Read-capture pipeline: the RAM byte for lane cap_k appears one cycle
  // after the CAPTURE state, so the lane index and "last byte" flag ride along.
  logic                  cap_pend_reg, cap_pend_next;
  logic [1:0]            cap_k_reg, cap_k_next;
  logic                  cap_last_reg, cap_last_next;
  logic [3:0]            hit_mask;
  logic [3:0]            fill_mask;
  logic [7:0]            fill_byte;

  // Index of the final byte: 0 for byte, 1 for half, 3 for word (size 11 = word).
  assign req_last_k = (size == 2'b00) ? 2'd0 :
                      (size == 2'b01) ? 2'd1 : 2'd3;

  // A request is taken only from an idle sequencer that is not showing done.
  assign accept = (state_reg == IDLE) && start && !busy_reg && !done_reg;

`ifdef RAM_SEQ_MISALIGN_TRAP_EN
  // Halves need an even address, words a 4-byte aligned one.
  assign misaligned = ((size == 2'b01) && address[0]) ||
                      (size[1] && (address[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Next-state and byte-index logic of the access sequencer
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          k_next     = 2'd0;
          state_next = misaligned ? DONE : SETUP;
        end
      end
      SETUP: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        if (k_reg == last_k_reg) begin
          state_next = DONE;
        end else begin
          k_next     = k_reg + 2'd1;
          state_next = SETUP;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sequencer state and the request fields latched when start is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      k_reg      <= 2'd0;
      last_k_reg <= 2'd0;
      addr_reg   <= '0;
      signed_reg <= 1'b0;
      write_reg  <= 1'b0;
      trap_reg   <= 1'b0;
      wdata_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      if (accept) begin
        last_k_reg <= req_last_k;
        addr_reg   <= address;
        signed_reg <= is_signed;
        write_reg  <= write;
        trap_reg   <= misaligned;
        wdata_reg  <= wdata;
      end
    end
  end

  // Output values derived from the current state, registered on the next edge
  always_comb begin
    ram_address_next = ram_address_reg;
    ram_data_in_next = ram_data_in_reg;
    ram_ce_next      = 1'b0;
    ram_we_next      = 1'b0;
    case (state_reg)
      SETUP: begin
        // Address wraps naturally at 2^ADDR_WIDTH through the truncated add.
        ram_address_next = addr_reg + {{(ADDR_WIDTH-2){1'b0}}, k_reg};
        ram_data_in_next = wdata_reg[8*k_reg +: 8];
        ram_ce_next      = 1'b1;
        ram_we_next      = write_reg;
      end
      CAPTURE: begin
        // Hold the strobe so the RAM sees a stable access for its read.
        ram_ce_next = ram_ce_reg;
        ram_we_next = ram_we_reg;
      end
      default: begin
      end
    endcase

    done_next  = (state_reg == DONE);
    error_next = (state_reg == DONE) && trap_reg;

    if (accept) begin
      busy_next = 1'b1;
    end else if (state_reg == DONE) begin
      busy_next = 1'b0;
    end else begin
      busy_next = busy_reg;
    end

    cap_pend_next = (state_reg == CAPTURE) && !write_reg;
    cap_k_next    = k_reg;
    cap_last_next = (k_reg == last_k_reg);
  end

  // Lane selection for the arriving read byte and the sign/zero fill above it
  assign hit_mask  = 4'b0001 << cap_k_reg;
  assign fill_mask = 4'b1110 << cap_k_reg;
  assign fill_byte = (signed_reg && ram_data_out[7]) ? 8'hFF : 8'h00;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      // Each rdata byte either takes the RAM byte, the fill byte on the final
      // capture of a short load, or keeps its value (stores never touch it).
      assign rdata_next[8*gi +: 8] =
        !cap_pend_reg                    ? rdata_reg[8*gi +: 8] :
        hit_mask[gi]                     ? ram_data_out :
        (cap_last_reg && fill_mask[gi])  ? fill_byte :
                                           rdata_reg[8*gi +: 8];
    end
  endgenerate

  // Registered outputs and the read-capture pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_reg       <= 32'd0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
      ram_address_reg <= '0;
      ram_data_in_reg <= 8'd0;
      ram_ce_reg      <= 1'b0;
      ram_we_reg      <= 1'b0;
      cap_pend_reg    <= 1'b0;
      cap_k_reg       <= 2'd0;
      cap_last_reg    <= 1'b0;
    end else begin
      rdata_reg       <= rdata_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      error_reg       <= error_next;
      ram_address_reg <= ram_address_next;
      ram_data_in_reg <= ram_data_in_next;
      ram_ce_reg      <= ram_ce_next;
      ram_we_reg      <= ram_we_next;
      cap_pend_reg    <= cap_pend_next;
      cap_k_reg       <= cap_k_next;
      cap_last_reg    <= cap_last_next;
    end
  end

  assign rdata            = rdata_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;
  assign error            = error_reg;
  assign ram_address      = ram_address_reg;
  assign ram_data_in      = ram_data_in_reg;
  assign ram_chip_enable  = ram_ce_reg;
  assign ram_write_enable = ram_we_reg;

endmodule

// File: tb/tb_ram_sequencer.sv
// Testbench for ram_sequencer: byte-wide synchronous RAM model, a
// byte-array reference memory, queue scoreboard and done-driven monitor.
// Honours RAM_SEQ_MISALIGN_TRAP_EN in the same way as the design.

module tb_ram_sequencer;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] address;
  logic [1:0]    size;
  logic          is_signed;
  logic          write;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data_in;
  logic [7:0]    ram_data_out;
  logic          ram_chip_enable;
  logic          ram_write_enable;

  ram_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .address          (address),
    .size             (size),
    .is_signed        (is_signed),
    .write            (write),
    .wdata            (wdata),
    .rdata            (rdata),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_data_out     (ram_data_out),
    .ram_chip_enable  (ram_chip_enable),
    .ram_write_enable (ram_write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide block RAM with registered read
  logic [7:0] ram_mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_chip_enable) begin
      if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
      ram_data_out <= ram_mem[ram_address];
    end
  end

  // Reference state
  logic [7:0]  ref_mem [0:DEPTH-1];
  logic [31:0] rdata_model;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          c0;
  } exp_t;
  exp_t sb[$];

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;
  int ce_cnt       = 0;
  int txn          = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ram_chip_enable) ce_cnt <= ce_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_trap(input int a, input int n);
`ifdef RAM_SEQ_MISALIGN_TRAP_EN
    return (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Little-endian assembly from the reference memory, then sign/zero fill.
  function automatic logic [31:0] model_load(input int a, input int n, input bit sg);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[(a + i) % DEPTH]) << (8 * i));
    if (n < 4 && sg && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // Issue one request once the sequencer is free; push its expectation.
  task automatic issue(input int a, input logic [1:0] sz, input bit sg,
                       input bit wr, input logic [31:0] wd);
    int   guard;
    int   n;
    bit   trap;
    exp_t e;
    guard = 0;
    while ((busy || done) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("issue_wait_busy", busy, 1'b0);
    address   = AW'(a);
    size      = sz;
    is_signed = sg;
    write     = wr;
    wdata     = wd;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n    = nbytes(sz);
    trap = is_trap(a, n);
    e.c0  = cyc;
    e.err = trap;
    e.lat = trap ? 1 : 2 * n + 1;
    if (!trap && wr) begin
      for (int i = 0; i < n; i++) ref_mem[(a + i) % DEPTH] = wd[8*i +: 8];
    end else if (!trap && !wr) begin
      rdata_model = model_load(a, n, sg);
    end
    e.rdata = rdata_model;
    sb.push_back(e);
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || busy || done) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset && done) begin
      if (sb.size() == 0) begin
        check("done_without_request", done, 1'b0);
      end else begin
        e = sb.pop_front();
        txn++;
        $display("txn %0d: rdata=0x%08h error=%0b latency=%0d", txn, rdata, error, cyc - e.c0);
        check("rdata", rdata, e.rdata);
        check("error", error, e.err);
        check("latency", 32'(cyc - e.c0), 32'(e.lat));
        check("ce_in_done", ram_chip_enable, 1'b0);
        check("we_in_done", ram_write_enable, 1'b0);
        check("busy_in_done", busy, 1'b0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_ram_address"}, 32'(ram_address), 32'd0);
    check({tag, "_ram_data_in"}, 32'(ram_data_in), 32'd0);
    check({tag, "_ce"}, ram_chip_enable, 1'b0);
    check({tag, "_we"}, ram_write_enable, 1'b0);
  endtask

  initial begin
    int      bad;
    int      a;
    int      ce_before;
    int      guard;
    logic [7:0] b;
    reset = 1'b0; start = 1'b0; address = '0; size = 2'b00;
    is_signed = 1'b0; write = 1'b0; wdata = 32'd0;
    rdata_model = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      ram_mem[i] = b;
      ref_mem[i] = b;
    end
    @(negedge clk); @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;   // released at a falling edge; start taken on next rising edge

    // Word store / load round trip
    issue(16'h0010, 2'b10, 1'b0, 1'b1, 32'h1122_3344);
    issue(16'h0010, 2'b10, 1'b0, 1'b0, 32'h0);
    wait_idle();
    check("ram_0010_word", {ram_mem[16'h13], ram_mem[16'h12], ram_mem[16'h11], ram_mem[16'h10]}, 32'h1122_3344);

    // Byte signed / unsigned
    issue(16'h0020, 2'b00, 1'b0, 1'b1, 32'h0000_0080);
    issue(16'h0020, 2'b00, 1'b1, 1'b0, 32'h0);
    issue(16'h0020, 2'b00, 1'b0, 1'b0, 32'h0);
    issue(16'h0021, 2'b11, 1'b1, 1'b0, 32'h0);  // size 11 treated as word

    // Half across the top of the address space
    issue(16'h3FFF, 2'b01, 1'b0, 1'b1, 32'h0000_BEEF);
    issue(16'h3FFF, 2'b01, 1'b1, 1'b0, 32'h0);
    wait_idle();
`ifndef RAM_SEQ_MISALIGN_TRAP_EN
    check("ram_wrap_half", {ram_mem[0], ram_mem[16'h3FFF]}, 32'h0000_BEEF);
`endif

    // Word load straddling the wrap point
    issue(16'h3FFF, 2'b10, 1'b0, 1'b0, 32'h0);
    wait_idle();

`ifdef RAM_SEQ_MISALIGN_TRAP_EN
    ce_before = ce_cnt;
    issue(16'h0002, 2'b10, 1'b0, 1'b0, 32'h0);
    wait_idle();
    check("trap_no_ram_access", 32'(ce_cnt - ce_before), 32'd0);
`else
    ce_before = ce_cnt;
`endif

    // Randomized traffic near both ends of the address space
    for (int t = 0; t < 50; t++) begin
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH - 4, DEPTH - 1))
                                       : int'($urandom_range(0, 63));
      issue(a, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom);
    end
    wait_idle();

    // start re-pulsed during a word load must be ignored
    issue(16'h0040, 2'b10, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    address = '0; size = 2'b10; write = 1'b1; wdata = $urandom; start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // start raised during the done cycle must be ignored
    issue(16'h0044, 2'b01, 1'b1, 1'b0, 32'h0);
    guard = 0;
    while (!done && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("done_seen", done, 1'b1);
    address = 14'h0050; size = 2'b10; write = 1'b1; wdata = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_done_start", busy, 1'b0);
    wait_idle();

    // Reset in the middle of a word store
    issue(16'h0100, 2'b10, 1'b0, 1'b1, 32'hA5A5_5A5A);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    rdata_model = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    issue(16'h0100, 2'b10, 1'b0, 1'b1, 32'hC0DE_F00D);
    issue(16'h0100, 2'b10, 1'b0, 1'b0, 32'h0);
    wait_idle();

    // Whole RAM image against the reference memory
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (ram_mem[i] !== ref_mem[i]) bad++;
    check("ram_image_bytes_differing", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
